matrix_stream_loader: RTL
=========================

Name: matrix_stream_loader

Overview:
Upstream feeder for the combinational float32 matrix multiplier. It accepts IEEE-754 single-precision elements one per beat over a valid/ready stream and assembles them into a flat row-major matrix bus of 32*ROWS*COLS bits. An optional transpose-on-load produces a column-major arrangement, such as a pre-transposed B operand. Two banks (double buffering) let the next matrix fill while the current one is held for the consumer.

Parameters:
ROWS, 1, row count of the incoming matrix (>=1)
COLS, 1, column count of the incoming matrix (>=1)
TRANSPOSE, 0, 0: output is ROWS x COLS row-major; 1: output is COLS x ROWS row-major (the transpose)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  32  float32 element; elements arrive in row-major order
in_valid  input  1  in_data/in_last are valid
in_last  input  1  marks the final element of a matrix
in_ready  output  1  loader can accept a beat
matrix  output  32*ROWS*COLS  presented matrix, flat; word k at bits [32*k +: 32]
out_valid  output  1  matrix holds a complete frame
out_ready  input  1  consumer accepts the frame
error  output  1  sticky framing error

Behaviour:
- N = ROWS*COLS. State: bank0, bank1 (N words each), idx (0..N-1), wr_sel, rd_sel, full[1:0], error.
- Reset (async, any time, including mid-frame): banks all-zero, idx=0, wr_sel=rd_sel=0, full=0, error=0. Therefore out_valid=0, matrix=0, in_ready=1. A partial frame is discarded.
- in_ready = !full[wr_sel] (combinational from registers; no dependency on in_valid).
- Accept = in_valid && in_ready. Element idx = r*COLS + c.
  - TRANSPOSE=0: written to word idx.
  - TRANSPOSE=1: written to word c*ROWS + r.
  - Written into bank[wr_sel].
- Frame end is the first of: accepted beat with idx==N-1, or accepted beat with in_last=1. On frame end: full[wr_sel]<=1, wr_sel toggles, idx<=0. Otherwise idx increments.
- Framing errors set error<=1, which stays set until reset:
  - in_last=1 at idx<N-1 (early last): the frame commits early. Unwritten words stay 0 (zero padding).
  - in_last=0 at idx==N-1 (missing last): the frame commits anyway.
- out_valid = full[rd_sel]; matrix = bank[rd_sel] (registered bank contents, muxed).
- Consume = out_valid && out_ready: full[rd_sel]<=0, bank[rd_sel] cleared to all-zero, rd_sel toggles.
- Latency: final beat accepted at edge t gives out_valid=1 after edge t, provided that bank is rd_sel. Otherwise it is presented the cycle after the older frame is consumed.
- Throughput: 1 element/cycle sustained. No bubble between frames while the consumer keeps up.
- Simultaneous accept and consume in one cycle are both legal. They never hit the same bank, because a bank being written is not full and a bank being read is full.
- Both banks full: in_ready=0 until a consume. in_ready returns to 1 the cycle after the consume.
- matrix is stable while out_valid=1 and out_ready=0.
- N==1: every accepted beat is a frame end.

Test Plan:
- ROWS=2, COLS=3, TRANSPOSE=0. Stream 1.0..6.0 (0x3F800000, 0x40000000, 0x40400000, 0x40800000, 0x40A00000, 0x40C00000), in_last on beat 6, out_ready=1 -> out_valid high the cycle after beat 6; words 0..5 = 1.0..6.0; error=0.
- Same stream with TRANSPOSE=1 -> words 0..5 = 1.0, 4.0, 2.0, 5.0, 3.0, 6.0.
- out_ready=0, send three back-to-back frames -> 12 beats accepted, then in_ready=0; first frame held stable. Pulse out_ready for one cycle -> second frame presented, in_ready=1 next cycle, third frame completes.
- Early last: in_last on beat 4 of a 6-element frame (values 1.0..4.0) -> frame committed; words 4 and 5 = 0x00000000; error=1 until rst.
- Missing last: 6 beats with in_last=0 -> frame committed after beat 6, error=1. Then a correct frame loads normally and error stays 1.
- Assert rst after beat 3 of a frame, with one full frame also pending -> out_valid=0, matrix=0, in_ready=1, error=0. A fresh 6-beat frame then loads from word 0.

Source files
------------

// File: rtl/matrix_stream_loader.sv
// Streams float32 elements into a double-buffered flat matrix bus, optionally
// transposing on load; framing problems raise a sticky error flag.
module matrix_stream_loader #(
   parameter int unsigned ROWS      = 1,
   parameter int unsigned COLS      = 1,
   parameter int unsigned TRANSPOSE = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [31:0]               in_data,
   input  logic                      in_valid,
   input  logic                      in_last,
   output logic                      in_ready,
   output logic [32*ROWS*COLS-1:0]   matrix,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      error
);

   localparam int unsigned N  = ROWS * COLS;
   localparam int unsigned IW = (N > 1)    ? $clog2(N)    : 1;
   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

   logic [32*N-1:0] bank [2];
   logic [IW-1:0]   idx;
   logic [IW-1:0]   waddr;
   logic [RW-1:0]   row;
   logic [CW-1:0]   col;
   logic            wr_sel;
   logic            rd_sel;
   logic [1:0]      full;
   logic            accept;
   logic            consume;
   logic            last_idx;
   logic            frame_end;

   assign in_ready  = !full[wr_sel];
   assign out_valid = full[rd_sel];
   assign matrix    = bank[rd_sel];

   // row/col track idx so the transposed address needs no divider
   always_comb begin
      accept    = in_valid && in_ready;
      consume   = out_valid && out_ready;
      last_idx  = (idx == IW'(N - 1));
      frame_end = accept && (last_idx || in_last);
      waddr     = (TRANSPOSE != 0) ? IW'(col) * IW'(ROWS) + IW'(row) : idx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank[0] <= '0;
         bank[1] <= '0;
         idx     <= '0;
         row     <= '0;
         col     <= '0;
         wr_sel  <= 1'b0;
         rd_sel  <= 1'b0;
         full    <= '0;
         error   <= 1'b0;
      end else begin
         if (accept) begin
            bank[wr_sel][32*waddr +: 32] <= in_data;
            if (frame_end) begin
               full[wr_sel] <= 1'b1;
               wr_sel       <= ~wr_sel;
               idx          <= '0;
               row          <= '0;
               col          <= '0;
               // early last or missing last
               if (in_last != last_idx)
                  error <= 1'b1;
            end else begin
               idx <= idx + IW'(1);
               if (col == CW'(COLS - 1)) begin
                  col <= '0;
                  row <= row + RW'(1);
               end else begin
                  col <= col + CW'(1);
               end
            end
         end
         // never the bank being written: that one is not full
         if (consume) begin
            full[rd_sel] <= 1'b0;
            bank[rd_sel] <= '0;
            rd_sel       <= ~rd_sel;
         end
      end
   end

endmodule
